// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the instruction fetch request path
package ibex_pkg;

    localparam int unsigned FETCH_WORD_BYTES = 4;

    typedef struct packed {
        logic valid;
        logic discard;
    } fetch_slot_t;

    typedef enum logic {
        REQ_IDLE,
        REQ_PEND
    } req_state_e;

    function automatic logic [31:0] word_align(logic [31:0] a);
        return a & ~32'(FETCH_WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/ibex_fetch_req_ctrl_if.sv
// ibex_fetch_req_ctrl_if: instr bus and fetch FIFO signals of the fetch request controller
interface ibex_fetch_req_ctrl_if;

    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        fifo_clear_o;
    logic        fifo_valid_o;
    logic        fifo_ready_i;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;

    modport master (
        output instr_req_o, instr_addr_o, fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_err_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i, fifo_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o, fifo_clear_o, fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_err_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_err_i, fifo_ready_i
    );

endinterface

// File: rtl/ibex_fetch_outstanding_q.sv
// ibex_fetch_outstanding_q: in-order queue of outstanding fetch slots, head at index 0
module ibex_fetch_outstanding_q import ibex_pkg::*; #(
    parameter int NUM_REQS = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            push_i,
    input  logic                            push_discard_i,
    input  logic                            pop_i,
    input  logic                            discard_all_i,
    output fetch_slot_t                     head_o,
    output logic [$clog2(NUM_REQS+1)-1:0]   count_o
);

    localparam int CW = $clog2(NUM_REQS + 1);

    fetch_slot_t [NUM_REQS-1:0] slots_q, slots_d;
    logic [CW-1:0] tail;
    logic pop;

    assign pop    = pop_i & slots_q[0].valid;
    assign head_o = slots_q[0];
    assign tail   = count_o - CW'(pop);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_REQS; i++) count_o = count_o + CW'(slots_q[i].valid);
    end

    // pop shifts towards the head, then the mark-all applies, then the push lands behind the survivors
    always_comb begin
        slots_d = slots_q;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (pop) slots_d[i] = (i + 1 < NUM_REQS) ? slots_q[(i + 1) % NUM_REQS] : '0;
            if (discard_all_i && slots_d[i].valid) slots_d[i].discard = 1'b1;
            if (push_i && CW'(i) == tail) slots_d[i] = '{valid: 1'b1, discard: push_discard_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) slots_q <= '0;
        else slots_q <= slots_d;
    end

    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> slots_q[0].valid);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_i && !pop_i |-> count_o < CW'(NUM_REQS));

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// ibex_fetch_req_ctrl: issues word-aligned instr bus requests, tracks them and feeds the fetch FIFO
module ibex_fetch_req_ctrl import ibex_pkg::*; #(
    parameter int NUM_REQS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    branch_i,
    input  logic [31:0]             branch_addr_i,
    output logic                    busy_o,
    ibex_fetch_req_ctrl_if.master   bus
);

    localparam int CW = $clog2(NUM_REQS + 1);

    req_state_e state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d, branch_addr_q, branch_addr_d;
    logic branch_pend_q, branch_pend_d;
    logic gnt;
    fetch_slot_t head;
    logic [CW-1:0] count;

    // a branch with nothing pending suppresses the request so the old address is never issued
    assign bus.instr_req_o  = state_q == REQ_PEND ||
                              (req_i && bus.fifo_ready_i && count < CW'(NUM_REQS) && !branch_i);
    assign gnt              = bus.instr_req_o & bus.instr_gnt_i;
    assign bus.instr_addr_o = fetch_addr_q;
    assign bus.fifo_clear_o = branch_i;
    assign bus.fifo_addr_o  = branch_addr_i;
    assign bus.fifo_rdata_o = bus.instr_rdata_i;
    assign bus.fifo_err_o   = bus.instr_err_i;
    assign bus.fifo_valid_o = bus.instr_rvalid_i & head.valid & ~head.discard & ~branch_i;
    assign busy_o           = head.valid | bus.instr_req_o;

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        branch_addr_d = branch_addr_q;
        branch_pend_d = branch_pend_q;
        if (gnt) begin
            state_d       = REQ_IDLE;
            branch_pend_d = 1'b0;
            fetch_addr_d  = branch_i ? word_align(branch_addr_i) :
                            branch_pend_q ? branch_addr_q : fetch_addr_q + 32'(FETCH_WORD_BYTES);
        end else if (bus.instr_req_o) begin
            state_d       = REQ_PEND;
            branch_pend_d = branch_pend_q | branch_i;
            branch_addr_d = branch_i ? word_align(branch_addr_i) : branch_addr_q;
        end else if (branch_i) begin
            fetch_addr_d  = word_align(branch_addr_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= REQ_IDLE;
            fetch_addr_q  <= '0;
            branch_addr_q <= '0;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            branch_addr_q <= branch_addr_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    ibex_fetch_outstanding_q #(.NUM_REQS(NUM_REQS)) u_outstanding (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .push_i         (gnt),
        .push_discard_i (branch_i | branch_pend_q),
        .pop_i          (bus.instr_rvalid_i),
        .discard_all_i  (branch_i),
        .head_o         (head),
        .count_o        (count)
    );

    a_obi_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.instr_req_o && !bus.instr_gnt_i |=> bus.instr_req_o && $stable(bus.instr_addr_o));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// tb_ibex_fetch_req_ctrl: directed bench with an in-order bus responder and a FIFO-write scoreboard
module tb_ibex_fetch_req_ctrl;

    typedef struct packed { logic [31:0] addr; logic disc; } inflight_t;
    typedef struct packed { logic [31:0] data; logic err; } exp_t;

    logic clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, branch_i = 1'b0, busy_o;
    logic [31:0] branch_addr_i = '0, err_addr = 32'hFFFF_FFFF;
    logic gnt_en = 1'b1, rsp_en = 1'b1, pend_br = 1'b0;
    int checks = 0, errors = 0, max_out = 0, err_seen = 0;
    inflight_t inflight[$];
    exp_t exp_q[$];
    logic [31:0] glog[$];

    ibex_fetch_req_ctrl_if bus();

    ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .busy_o        (busy_o),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;
    assign bus.instr_gnt_i = gnt_en & bus.instr_req_o;

    function automatic logic [31:0] data_of(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(logic [31:0] exp);
        logic [31:0] a;
        a = 32'hDEAD_BEEF;
        if (glog.size() != 0) a = glog.pop_front();
        chk("grant_addr", a, exp);
    endtask

    // drive this cycle's response, then at the falling edge score the FIFO write and update the bus model
    task automatic half();
        exp_t e;
        bus.instr_rvalid_i = rsp_en && inflight.size() != 0;
        if (bus.instr_rvalid_i) begin
            bus.instr_rdata_i = data_of(inflight[0].addr);
            bus.instr_err_i   = inflight[0].addr == err_addr;
            if (!inflight[0].disc && !branch_i) exp_q.push_back('{bus.instr_rdata_i, bus.instr_err_i});
        end
        @(negedge clk_i);
        chk("fifo_valid", 32'(bus.fifo_valid_o), 32'(exp_q.size() != 0));
        if (bus.fifo_valid_o && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("fifo_rdata", bus.fifo_rdata_o, e.data);
            chk("fifo_err", 32'(bus.fifo_err_o), 32'(e.err));
            err_seen += int'(bus.fifo_err_o);
        end
        exp_q.delete();
        if (bus.instr_rvalid_i) inflight.delete(0);
        if (branch_i) foreach (inflight[i]) inflight[i].disc = 1'b1;
        if (bus.instr_req_o && bus.instr_gnt_i) begin
            inflight.push_back('{bus.instr_addr_o, branch_i | pend_br});
            glog.push_back(bus.instr_addr_o);
            pend_br = 1'b0;
        end else if (bus.instr_req_o && branch_i) pend_br = 1'b1;
        if (inflight.size() > max_out) max_out = inflight.size();
    endtask

    task automatic fin();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc();
        half();
        fin();
    endtask

    initial begin
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = '0;
        bus.instr_err_i    = 1'b0;
        bus.fifo_ready_i   = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_req", 32'(bus.instr_req_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_fifo_valid", 32'(bus.fifo_valid_o), 0);
        fin();
        rst_ni = 1'b1;

        // branch to 0x100, then stream with gnt every cycle and rvalid one cycle later
        branch_i = 1'b1; branch_addr_i = 32'h100; req_i = 1'b1;
        half();
        chk("clear_on_branch", 32'(bus.fifo_clear_o), 1);
        chk("clear_addr", bus.fifo_addr_o, 32'h100);
        chk("no_req_in_branch", 32'(bus.instr_req_o), 0);
        fin();
        branch_i = 1'b0;
        repeat (3) cyc();
        req_i = 1'b0;
        repeat (2) cyc();
        chk_addr(32'h100); chk_addr(32'h104); chk_addr(32'h108);
        half(); chk("idle_busy", 32'(busy_o), 0); fin();

        // grant withheld five cycles, branch to 0x200 in the second
        branch_i = 1'b1; branch_addr_i = 32'h100; cyc(); branch_i = 1'b0;
        req_i = 1'b1; cyc();
        gnt_en = 1'b0; cyc();
        branch_i = 1'b1; branch_addr_i = 32'h200;
        half();
        chk("hold_clear", 32'(bus.fifo_clear_o), 1);
        chk("hold_addr", bus.instr_addr_o, 32'h104);
        chk("hold_req", 32'(bus.instr_req_o), 1);
        fin();
        branch_i = 1'b0;
        repeat (3) begin
            half();
            chk("hold_addr", bus.instr_addr_o, 32'h104);
            chk("hold_req", 32'(bus.instr_req_o), 1);
            chk("hold_no_clear", 32'(bus.fifo_clear_o), 0);
            fin();
        end
        gnt_en = 1'b1; cyc();
        cyc();
        req_i = 1'b0; cyc();
        chk_addr(32'h100); chk_addr(32'h104); chk_addr(32'h200);

        // two outstanding, then branch to 0x302 drops both
        rsp_en = 1'b0; req_i = 1'b1; cyc(); cyc();
        half();
        chk("full_no_req", 32'(bus.instr_req_o), 0);
        chk("full_busy", 32'(busy_o), 1);
        fin();
        req_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h302;
        half();
        chk("clear_addr_unaligned", bus.fifo_addr_o, 32'h302);
        chk("clear_on_branch", 32'(bus.fifo_clear_o), 1);
        fin();
        branch_i = 1'b0; rsp_en = 1'b1; cyc(); cyc();
        req_i = 1'b1; cyc(); req_i = 1'b0; cyc();
        chk_addr(32'h204); chk_addr(32'h208); chk_addr(32'h300);
        chk("max_outstanding", 32'(max_out), 2);

        // FIFO not ready blocks new requests
        bus.fifo_ready_i = 1'b0; req_i = 1'b1;
        repeat (2) begin half(); chk("ready_low_no_req", 32'(bus.instr_req_o), 0); fin(); end
        bus.fifo_ready_i = 1'b1;
        half(); chk("ready_high_req", 32'(bus.instr_req_o), 1); fin();
        req_i = 1'b0; cyc();
        chk_addr(32'h304);

        // error response at 0x104 is forwarded, fetching continues
        err_addr = 32'h104;
        branch_i = 1'b1; branch_addr_i = 32'h100; cyc(); branch_i = 1'b0;
        req_i = 1'b1; repeat (3) cyc();
        req_i = 1'b0; cyc();
        chk_addr(32'h100); chk_addr(32'h104); chk_addr(32'h108);
        chk("err_seen", 32'(err_seen), 1);

        // address wrap
        branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC; cyc(); branch_i = 1'b0;
        req_i = 1'b1; cyc(); cyc();
        req_i = 1'b0; cyc();
        chk_addr(32'hFFFF_FFFC); chk_addr(32'h0);

        // branch coinciding with a grant and with a response
        branch_i = 1'b1; branch_addr_i = 32'h400; cyc(); branch_i = 1'b0;
        req_i = 1'b1; cyc(); cyc();
        gnt_en = 1'b0; rsp_en = 1'b0; cyc();
        gnt_en = 1'b1; rsp_en = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h500; cyc();
        branch_i = 1'b0; cyc();
        req_i = 1'b0; cyc(); cyc();
        chk_addr(32'h400); chk_addr(32'h404); chk_addr(32'h408); chk_addr(32'h500);

        // asynchronous reset with a request outstanding
        rsp_en = 1'b0; req_i = 1'b1; cyc(); req_i = 1'b0;
        half(); chk("busy_outstanding", 32'(busy_o), 1); fin();
        chk_addr(32'h504);
        rst_ni = 1'b0; inflight.delete(); pend_br = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_req", 32'(bus.instr_req_o), 0);
        fin();
        rst_ni = 1'b1; rsp_en = 1'b1;
        half(); chk("post_rst_addr", bus.instr_addr_o, 32'h0); fin();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
